// File: rtl/complex_div_arbiter_if.sv
// Bundle of requester, response, unit-side and control signals for complex_div_arbiter.
// The COMPLEX_DIV_ARB_PERF_EN macro adds the performance counter outputs.
interface complex_div_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0][3:0][63:0] req_operands_i;

    logic [NUM_REQ-1:0]            rsp_valid_o;
    logic [NUM_REQ-1:0]            rsp_ready_i;
    logic [1:0][63:0]              rsp_result_o;
    logic [4:0]                    rsp_status_o;

    logic                          unit_valid_o;
    logic                          unit_ready_i;
    logic [3:0][63:0]              unit_operands_o;
    logic                          unit_valid_i;
    logic                          unit_ready_o;
    logic [1:0][63:0]              unit_result_i;
    logic [4:0]                    unit_status_i;
    logic                          unit_flush_o;

    logic                          flush_i;
    logic                          busy_o;
    logic                          err_o;
`ifdef COMPLEX_DIV_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0]      perf_grant_o;
    logic [31:0]                   perf_stall_o;
`endif

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // valid never depends on ready from the same side, ready may depend on valid.
    modport slave (
        input  req_valid_i, req_operands_i, rsp_ready_i,
        input  unit_ready_i, unit_valid_i, unit_result_i, unit_status_i, flush_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
        output unit_valid_o, unit_operands_o, unit_ready_o, unit_flush_o,
        output busy_o, err_o
`ifdef COMPLEX_DIV_ARB_PERF_EN
        , output perf_grant_o, perf_stall_o
`endif
    );

    modport master (
        output req_valid_i, req_operands_i, rsp_ready_i,
        output unit_ready_i, unit_valid_i, unit_result_i, unit_status_i, flush_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
        input  unit_valid_o, unit_operands_o, unit_ready_o, unit_flush_o,
        input  busy_o, err_o
`ifdef COMPLEX_DIV_ARB_PERF_EN
        , input perf_grant_o, perf_stall_o
`endif
    );
endinterface

// File: rtl/complex_div_arbiter.sv
// Round-robin arbiter sharing one pipelined complex divider among NUM_REQ requesters,
// routing responses back in issue order via an ID FIFO. COMPLEX_DIV_ARB_PERF_EN adds counters.
module complex_div_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_DEPTH = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    complex_div_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(ID_DEPTH);
    localparam int CW = PW + 1;

    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] id_mem_q [ID_DEPTH];
    logic [GW-1:0] id_mem_d [ID_DEPTH];
    logic          err_q, err_d;

    logic [GW-1:0] grant;
    logic [GW-1:0] head_id;
    logic          any_req, full, empty, issue, rsp_take, orphan;

    // The nearest valid requester after 'last' wins, so scan from farthest to nearest.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic [GW-1:0] jj;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            jj = GW'((int'(last) + k) % NUM_REQ);
            if (v[jj]) pick = jj;
        end
        return pick;
    endfunction

    always_comb begin
        grant    = rr_pick(bus.req_valid_i, last_grant_q);
        any_req  = |bus.req_valid_i;
        full     = (count_q == CW'(ID_DEPTH));
        empty    = (count_q == '0);
        head_id  = id_mem_q[rd_ptr_q];

        bus.unit_valid_o    = any_req & ~full & ~bus.flush_i & ~rst_i;
        bus.unit_operands_o = bus.req_operands_i[grant];
        issue               = bus.unit_valid_o & bus.unit_ready_i;
        bus.req_ready_o     = '0;
        if (issue) bus.req_ready_o[grant] = 1'b1;

        // With nothing outstanding the unit's result is an orphan and is simply absorbed.
        bus.unit_ready_o = empty ? 1'b1 : bus.rsp_ready_i[head_id];
        bus.rsp_valid_o  = '0;
        if (bus.unit_valid_i & ~empty & ~bus.flush_i & ~rst_i) bus.rsp_valid_o[head_id] = 1'b1;
        rsp_take = bus.unit_valid_i & bus.unit_ready_o & ~empty;
        orphan   = bus.unit_valid_i & empty;

        bus.rsp_result_o = bus.unit_result_i;
        bus.rsp_status_o = bus.unit_status_i;
        bus.unit_flush_o = bus.flush_i;
        bus.busy_o       = (count_q != '0);
        bus.err_o        = err_q;
    end

    always_comb begin
        last_grant_d = issue ? grant : last_grant_q;
        err_d        = err_q | orphan;
        id_mem_d     = id_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                id_mem_d[wr_ptr_q] = grant;
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
            if (rsp_take) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(issue) - CW'(rsp_take);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= GW'(NUM_REQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < ID_DEPTH; i++) id_mem_q[i] <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            id_mem_q     <= id_mem_d;
        end
    end

`ifdef COMPLEX_DIV_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] perf_grant_q, perf_grant_d;
    logic [31:0]              perf_stall_q, perf_stall_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        perf_grant_d = perf_grant_q;
        perf_stall_d = perf_stall_q;
        if (issue && (perf_grant_q[grant] != '1)) perf_grant_d[grant] = perf_grant_q[grant] + 32'd1;
        if (bus.unit_valid_o && !bus.unit_ready_i && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 32'd1;
        bus.perf_grant_o = perf_grant_q;
        bus.perf_stall_o = perf_stall_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_stall_q <= perf_stall_d;
        end
    end
`endif
endmodule

// File: tb/tb_complex_div_arbiter.sv
// Bench for complex_div_arbiter: directed vector table, corner sequences, and randomized
// cycles checked against a queue-based reference model. Honours COMPLEX_DIV_ARB_PERF_EN.
module tb_complex_div_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int ID_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    complex_div_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    complex_div_arbiter #(.NUM_REQ(NUM_REQ), .ID_DEPTH(ID_DEPTH)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] rv;
        logic       ur;
        logic       uv;
        logic [3:0] rr;
        logic       fl;
        logic [3:0] e_rdy;
        logic       e_uvo;
        logic [3:0] e_rsp;
        logic       e_ur;
        logic       e_busy;
    } vec_t;

    vec_t vq[$];

    // Reference model: outstanding requester IDs in issue order plus arbitration pointer.
    int m_last;
    int m_q[$];
    bit m_err;
    bit s_push, s_pop, s_orphan, s_flush, s_rst;
    int s_g;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic ur, input logic uv,
                                input logic [3:0] rr, input logic fl, input logic [3:0] e_rdy,
                                input logic e_uvo, input logic [3:0] e_rsp, input logic e_ur,
                                input logic e_busy);
        return {rv, ur, uv, rr, fl, e_rdy, e_uvo, e_rsp, e_ur, e_busy};
    endfunction

    task automatic drive(input logic [3:0] rv, input logic ur, input logic uv,
                         input logic [3:0] rr, input logic fl);
        bus.req_valid_i  = rv;
        bus.unit_ready_i = ur;
        bus.unit_valid_i = uv;
        bus.rsp_ready_i  = rr;
        bus.flush_i      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last = NUM_REQ - 1;
        m_q.delete();
        m_err = 1'b0;
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        drive(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_unit_valid", bus.unit_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_unit_flush", bus.unit_flush_o, 0);
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic check_cycle();
        int  g;
        bit  full, empty, e_uv, e_ur;
        logic [NUM_REQ-1:0] e_rdy, e_rsp;
        g     = model_pick(bus.req_valid_i);
        full  = (m_q.size() == ID_DEPTH);
        empty = (m_q.size() == 0);
        e_uv  = (g >= 0) && !full && !bus.flush_i && !rst;
        e_rdy = (e_uv && bus.unit_ready_i) ? NUM_REQ'(1 << g) : '0;
        e_rsp = (bus.unit_valid_i && !empty && !bus.flush_i && !rst) ? NUM_REQ'(1 << m_q[0]) : '0;
        e_ur  = empty ? 1'b1 : bus.rsp_ready_i[m_q[0]];
        chk("rnd_unit_valid", bus.unit_valid_o, e_uv);
        chk("rnd_req_ready", bus.req_ready_o, e_rdy);
        chk("rnd_rsp_valid", bus.rsp_valid_o, e_rsp);
        chk("rnd_unit_ready", bus.unit_ready_o, e_ur);
        chk("rnd_busy", bus.busy_o, !empty);
        chk("rnd_err", bus.err_o, m_err);
        chk("rnd_unit_flush", bus.unit_flush_o, bus.flush_i);
        chk("rnd_result", bus.rsp_result_o, bus.unit_result_i);
        chk("rnd_status", bus.rsp_status_o, bus.unit_status_i);
        if (e_uv) chk("rnd_operands", bus.unit_operands_o, bus.req_operands_i[g]);
        s_push   = e_uv && bus.unit_ready_i;
        s_g      = g;
        s_pop    = bus.unit_valid_i && e_ur && !empty;
        s_orphan = bus.unit_valid_i && empty;
        s_flush  = bus.flush_i;
        s_rst    = rst;
    endtask

    task automatic model_edge();
        if (s_rst) begin
            model_reset();
        end else begin
            if (s_orphan) m_err = 1'b1;
            if (s_flush) begin
                m_q.delete();
            end else begin
                if (s_pop) void'(m_q.pop_front());
                if (s_push) m_q.push_back(s_g);
            end
            if (s_push) m_last = s_g;
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) bus.req_operands_i[i] = {4{64'(i + 1) * 64'h1111}};
        bus.unit_result_i = {64'hAAAA_0001, 64'hBBBB_0002};
        bus.unit_status_i = 5'b00101;
        do_reset();

        // Round-robin streaming, in-order routing with backpressure, full FIFO, flush.
        vq.push_back(mk(4'hF, 1, 0, 4'hF, 0, 4'b0001, 1, 4'b0000, 1, 0));
        vq.push_back(mk(4'hF, 1, 1, 4'hF, 0, 4'b0010, 1, 4'b0001, 1, 1));
        vq.push_back(mk(4'hF, 1, 1, 4'hF, 0, 4'b0100, 1, 4'b0010, 1, 1));
        vq.push_back(mk(4'hF, 1, 1, 4'hF, 0, 4'b1000, 1, 4'b0100, 1, 1));
        vq.push_back(mk(4'hF, 1, 1, 4'hF, 0, 4'b0001, 1, 4'b1000, 1, 1));
        vq.push_back(mk(4'h0, 1, 1, 4'hF, 0, 4'b0000, 0, 4'b0001, 1, 1));
        vq.push_back(mk(4'h0, 0, 0, 4'h0, 0, 4'b0000, 0, 4'b0000, 1, 0));
        vq.push_back(mk(4'h4, 1, 0, 4'h0, 0, 4'b0100, 1, 4'b0000, 1, 0));
        vq.push_back(mk(4'h1, 1, 0, 4'h0, 0, 4'b0001, 1, 4'b0000, 0, 1));
        vq.push_back(mk(4'h0, 0, 1, 4'hB, 0, 4'b0000, 0, 4'b0100, 0, 1));
        vq.push_back(mk(4'h0, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0100, 1, 1));
        vq.push_back(mk(4'h0, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0001, 1, 1));
        vq.push_back(mk(4'h0, 0, 0, 4'hF, 0, 4'b0000, 0, 4'b0000, 1, 0));
        vq.push_back(mk(4'hF, 1, 0, 4'h0, 0, 4'b0010, 1, 4'b0000, 1, 0));
        vq.push_back(mk(4'hF, 1, 0, 4'h0, 0, 4'b0100, 1, 4'b0000, 0, 1));
        vq.push_back(mk(4'hF, 1, 0, 4'h0, 0, 4'b1000, 1, 4'b0000, 0, 1));
        vq.push_back(mk(4'hF, 1, 0, 4'h0, 0, 4'b0001, 1, 4'b0000, 0, 1));
        vq.push_back(mk(4'hF, 1, 0, 4'h0, 0, 4'b0000, 0, 4'b0000, 0, 1));
        vq.push_back(mk(4'hF, 1, 1, 4'hF, 0, 4'b0000, 0, 4'b0010, 1, 1));
        vq.push_back(mk(4'hF, 1, 0, 4'h0, 0, 4'b0010, 1, 4'b0000, 0, 1));
        vq.push_back(mk(4'h0, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0100, 1, 1));
        vq.push_back(mk(4'hF, 1, 1, 4'hF, 1, 4'b0000, 0, 4'b0000, 1, 1));
        vq.push_back(mk(4'hF, 1, 0, 4'h0, 0, 4'b0100, 1, 4'b0000, 1, 0));
        vq.push_back(mk(4'h0, 0, 1, 4'hF, 0, 4'b0000, 0, 4'b0100, 1, 1));
        vq.push_back(mk(4'h0, 0, 0, 4'h0, 0, 4'b0000, 0, 4'b0000, 1, 0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rv, vq[i].ur, vq[i].uv, vq[i].rr, vq[i].fl);
            #1;
            chk($sformatf("vec%0d_req_ready", i), bus.req_ready_o, vq[i].e_rdy);
            chk($sformatf("vec%0d_unit_valid", i), bus.unit_valid_o, vq[i].e_uvo);
            chk($sformatf("vec%0d_rsp_valid", i), bus.rsp_valid_o, vq[i].e_rsp);
            chk($sformatf("vec%0d_unit_ready", i), bus.unit_ready_o, vq[i].e_ur);
            chk($sformatf("vec%0d_busy", i), bus.busy_o, vq[i].e_busy);
            chk($sformatf("vec%0d_unit_flush", i), bus.unit_flush_o, vq[i].fl);
            if (vq[i].e_rsp != 0) chk($sformatf("vec%0d_result", i), bus.rsp_result_o,
                                      {64'hAAAA_0001, 64'hBBBB_0002});
            tick();
        end

        // Orphan response straight after reset sets a sticky error.
        do_reset();
        drive(4'h0, 0, 1, 4'h0, 0);
        #1;
        chk("orphan_unit_ready", bus.unit_ready_o, 1);
        chk("orphan_rsp_valid", bus.rsp_valid_o, 0);
        chk("orphan_err_same_cycle", bus.err_o, 0);
        tick();
        drive(4'h0, 0, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("orphan_err_sticky", bus.err_o, 1);
            tick();
        end

        // Reset mid-operation discards outstanding IDs; the late response is an orphan.
        do_reset();
        drive(4'h1, 1, 0, 4'h0, 0);
        tick();
        tick();
        drive(4'h0, 0, 0, 4'h0, 0);
        #1;
        chk("midrst_busy_before", bus.busy_o, 1);
        rst = 1'b1;
        drive(4'h1, 1, 1, 4'hF, 0);
        #1;
        chk("midrst_req_ready_in_reset", bus.req_ready_o, 0);
        chk("midrst_rsp_valid_in_reset", bus.rsp_valid_o, 0);
        tick();
        rst = 1'b0;
        drive(4'h0, 0, 1, 4'hF, 0);
        #1;
        chk("midrst_busy_after", bus.busy_o, 0);
        chk("midrst_rsp_valid", bus.rsp_valid_o, 0);
        chk("midrst_unit_ready", bus.unit_ready_o, 1);
        tick();
        drive(4'h0, 0, 0, 4'h0, 0);
        #1;
        chk("midrst_err", bus.err_o, 1);

`ifdef COMPLEX_DIV_ARB_PERF_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'h2, 1, (i != 0), 4'hF, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'h2, 0, 1, 4'hF, 0);
            tick();
        end
        drive(4'h0, 0, 0, 4'h0, 0);
        #1;
        chk("perf_grant1", bus.perf_grant_o[1], 5);
        chk("perf_grant0", bus.perf_grant_o[0], 0);
        chk("perf_stall", bus.perf_stall_o, 3);
        tick();
`endif

        // Randomized traffic against the model, with occasional flush and reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 49) == 0));
            for (int i = 0; i < NUM_REQ; i++)
                bus.req_operands_i[i] = {$urandom, $urandom, $urandom, $urandom,
                                         $urandom, $urandom, $urandom, $urandom};
            bus.unit_result_i = {$urandom, $urandom, $urandom, $urandom};
            bus.unit_status_i = 5'($urandom_range(0, 31));
            #1;
            check_cycle();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/complex_div_arbiter.md
COMPLEX_DIV_ARBITER -- requirements
Module: complex_div_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter ID_DEPTH, default 4, meaning the maximum outstanding operations in the shared unit (power of 2, 2..16).
REQ-003 The block SHALL have one clock and synchronous active-high reset, declared as: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-004 Requester ports SHALL be: req_valid_i  in  NUM_REQ  request valid; req_ready_o  out  NUM_REQ  request accepted; req_operands_i  in  NUM_REQ x 4 x 64  {b2,a2,b1,a1} per requester.
REQ-005 Response ports SHALL be: rsp_valid_o  out  NUM_REQ  response valid; rsp_ready_i  in  NUM_REQ  response taken; rsp_result_o  out  2 x 64  broadcast quotient; rsp_status_o  out  5  broadcast fpnew_pkg::status_t.
REQ-006 Unit-side ports SHALL be: unit_valid_o  out  1; unit_ready_i  in  1; unit_operands_o  out  4 x 64; unit_valid_i  in  1; unit_ready_o  out  1; unit_result_i  in  2 x 64; unit_status_i  in  5; unit_flush_o  out  1.
REQ-007 Control ports SHALL be: flush_i  in  1  abort all in-flight work; busy_o  out  1  outstanding count non-zero; err_o  out  1  sticky orphan-response flag.

Function
REQ-008 Arbitration SHALL be round-robin over req_valid_i, starting search at index last_grant+1 (mod NUM_REQ); grant is combinational, zero added latency.
REQ-009 unit_valid_o SHALL equal (any req_valid_i) AND (ID FIFO not full) AND NOT flush_i; unit_operands_o SHALL carry the granted requester's operands.
REQ-010 req_ready_o[g] SHALL be 1 only for granted index g and only when unit_ready_i AND unit_valid_o; all other bits 0.
REQ-011 On issue handshake (unit_valid_o & unit_ready_i) the block SHALL push g into the ID FIFO and set last_grant to g.
REQ-012 last_grant SHALL hold when no handshake occurs; a requester holding valid SHALL be granted within NUM_REQ issue handshakes.
REQ-013 When unit_valid_i and FIFO not empty, rsp_valid_o[head] SHALL be 1 (others 0), unit_ready_o SHALL equal rsp_ready_i[head], and rsp_result_o/rsp_status_o SHALL pass unit_result_i/unit_status_i through.
REQ-014 On response handshake (unit_valid_i & unit_ready_o) the FIFO head SHALL pop.
REQ-015 Simultaneous push and pop SHALL both occur; count unchanged; pointers wrap modulo ID_DEPTH.
REQ-016 Push SHALL be blocked when count == ID_DEPTH even if a pop occurs in the same cycle.
REQ-017 unit_valid_i with FIFO empty SHALL be dropped: unit_ready_o = 1, no rsp_valid_o, err_o set to 1 next cycle and held until reset.
REQ-018 flush_i SHALL drive unit_flush_o combinationally, force unit_valid_o, req_ready_o, rsp_valid_o to 0, and clear FIFO count/pointers next cycle; last_grant unchanged.
REQ-019 busy_o SHALL be 1 iff FIFO count != 0 (registered state).

Reset
REQ-020 With rst_i high at a clock edge: FIFO pointers and count = 0, last_grant = NUM_REQ-1, err_o = 0, any performance counters = 0.
REQ-021 During and after reset all outputs SHALL be: req_ready_o 0, rsp_valid_o 0, unit_valid_o 0 while no request, busy_o 0, unit_flush_o = flush_i.
REQ-022 Reset mid-operation SHALL discard outstanding IDs; later unit responses count as orphans (REQ-017).

Configuration
REQ-023 Macro COMPLEX_DIV_ARB_PERF_EN defined: the block SHALL add output perf_grant_o (NUM_REQ x 32, per-requester issue count) and perf_stall_o (32, cycles with unit_valid_o & ~unit_ready_i), both saturating at 2^32-1, cleared by reset only.
REQ-024 Macro not defined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-025 Reset, then all four req_valid_i=1, unit_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-026 Issue from req 2 then req 0, unit returns two results -> rsp_valid_o = 4'b0100 then 4'b0001, results in issue order.
REQ-027 Issue 4 with unit_valid_i=0 -> busy_o=1, unit_valid_o=0 with requests pending; 1 pop + request same cycle -> no push that cycle, push next.
REQ-028 unit_valid_i=1 after reset with no issue -> unit_ready_o=1, rsp_valid_o=0, err_o=1 next cycle and stays.
REQ-029 3 outstanding, flush_i=1 one cycle -> unit_flush_o=1 that cycle, busy_o=0 next cycle, next grant continues from last_grant+1.
REQ-030 With COMPLEX_DIV_ARB_PERF_EN: 5 issues from req 1, 3 stall cycles -> perf_grant_o[1]=5, perf_stall_o=3.
